// File: rtl/contador_pkg.sv
// Shared types and constants for the 4-digit BCD counter: digit limits and
// the load-path clamp that keeps every stored nibble a legal BCD digit.
package contador_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIG_MAX = 4'd9;
  localparam bcd_t DIG_MIN = 4'd0;
  localparam int   N_DIG   = 4;

  function automatic bcd_t clamp_digit(input bcd_t x);
    return (x > DIG_MAX) ? DIG_MAX : x;
  endfunction

endpackage

// File: rtl/digito_bcd.sv
// One BCD digit, up/down, with synchronous load. co fires when this digit
// rolls over in the current direction, so digits chain by feeding co into ce.
module digito_bcd
  import contador_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       up,
  input  logic       ld,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       co
);

  bcd_t q_q, q_d;

  // NOTE: q_d gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (ce) begin
      if (up) q_d = (q_q == DIG_MAX) ? DIG_MIN : q_q + 4'd1;
      else    q_d = (q_q == DIG_MIN) ? DIG_MAX : q_q - 4'd1;
    end
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values, whatever the block order.
  always_ff @(posedge clk) begin
    if (reset) q_q <= DIG_MIN;
    else       q_q <= q_d;
  end

  assign q  = q_q;
  assign co = ce & (up ? (q_q == DIG_MAX) : (q_q == DIG_MIN));

endmodule

// File: rtl/contador_bcd_9999.sv
// 4-digit BCD up/down counter 0000..9999 with a prescaler that produces one
// count step every DIV enabled cycles; tick/wrap flag the cycle q shows a step.
module contador_bcd_9999
  import contador_pkg::*;
#(
  parameter int DIV   = 50_000_000,
  parameter int DIV_W = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        up,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] d_in,
  output logic [15:0] q,
  output logic        tick,
  output logic        wrap
);

  localparam logic [DIV_W-1:0] P_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] p_q, p_d;
  logic             tick_q, wrap_q;
  logic             ld_any, step;
  logic [15:0]      ld_val;
  logic [N_DIG:0]   carry;

  // clr is folded into the digit load path as a load of zero.
  assign ld_any = clr | load;
  assign step   = en & ~ld_any & (p_q == P_LAST);

  always_comb begin
    ld_val = '0;
    if (!clr) begin
      for (int i = 0; i < N_DIG; i++) ld_val[4*i +: 4] = clamp_digit(d_in[4*i +: 4]);
    end
  end

  always_comb begin
    p_d = p_q;
    if (ld_any)  p_d = '0;
    else if (en) p_d = (p_q == P_LAST) ? '0 : p_q + DIV_W'(1);
  end

  assign carry[0] = step;

  for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
    digito_bcd u_dig (
      .clk   (clk),
      .reset (reset),
      .ce    (carry[gi]),
      .up    (up),
      .ld    (ld_any),
      .d     (ld_val[4*gi +: 4]),
      .q     (q[4*gi +: 4]),
      .co    (carry[gi+1])
    );
  end

  // The thousands carry already includes step, so it is the wrap condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q    <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      tick_q <= step;
      wrap_q <= carry[N_DIG];
    end
  end

  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_contador_bcd_9999.sv
// Bench for contador_bcd_9999 with DIV=4: directed vector table, hand-written
// corner sequences and randomized traffic against an integer reference model.
module tb_contador_bcd_9999;

  localparam int DIV   = 4;
  localparam int DIV_W = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1, en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [15:0] d_in = '0;
  logic [15:0] q;
  logic        tick, wrap;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: decimal count value and prescaler phase as plain integers.
  int m_cnt = 0;
  int m_p   = 0;
  bit m_tick = 0;
  bit m_wrap = 0;

  typedef struct {
    bit          r, e, u, c, l;
    logic [15:0] d;
    logic [15:0] exp_q;
    bit          exp_tick, exp_wrap;
  } vec_t;

  vec_t vecs[$];

  contador_bcd_9999 #(.DIV(DIV), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .up    (up),
    .clr   (clr),
    .load  (load),
    .d_in  (d_in),
    .q     (q),
    .tick  (tick),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_to_int(input logic [15:0] d);
    int v = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      int nib = int'(d[4*i +: 4]);
      v += ((nib > 9) ? 9 : nib) * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic void model(input bit r, e, u, c, l, input logic [15:0] d);
    m_tick = 0;
    m_wrap = 0;
    if (r || c) begin
      m_cnt = 0;
      m_p   = 0;
    end else if (l) begin
      m_cnt = clamp_to_int(d);
      m_p   = 0;
    end else if (e) begin
      if (m_p == DIV - 1) begin
        m_p    = 0;
        m_tick = 1;
        if (u) begin
          m_wrap = (m_cnt == 9999);
          m_cnt  = (m_cnt + 1) % 10000;
        end else begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + 9999) % 10000;
        end
      end else begin
        m_p++;
      end
    end
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, return at the next falling edge.
  task automatic cyc(input bit r, e, u, c, l, input logic [15:0] d);
    reset = r; en = e; up = u; clr = c; load = l; d_in = d;
    model(r, e, u, c, l, d);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"},    q,           to_bcd(m_cnt));
    check({tag, ".tick"}, 16'(tick),   16'(m_tick));
    check({tag, ".wrap"}, 16'(wrap),   16'(m_wrap));
  endtask

  function automatic void add(input int n, input bit r, e, u, c, l, input logic [15:0] d,
                              input logic [15:0] eq, input bit et, ew);
    for (int i = 0; i < n; i++) vecs.push_back('{r, e, u, c, l, d, eq, et, ew});
  endfunction

  initial begin
    // Directed vectors; expectations are literal values from the counting rules.
    add(1, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(3, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(1, 0, 1, 1, 0, 0, 16'h0000, 16'h0001, 1, 0);
    add(3, 0, 1, 1, 0, 0, 16'h0000, 16'h0001, 0, 0);
    add(1, 0, 1, 1, 0, 0, 16'h0000, 16'h0002, 1, 0);
    add(1, 0, 1, 1, 0, 1, 16'h0009, 16'h0009, 0, 0);
    add(3, 0, 1, 1, 0, 0, 16'h0000, 16'h0009, 0, 0);
    add(1, 0, 1, 1, 0, 0, 16'h0000, 16'h0010, 1, 0);
    add(1, 0, 1, 1, 0, 1, 16'h0999, 16'h0999, 0, 0);
    add(3, 0, 1, 1, 0, 0, 16'h0000, 16'h0999, 0, 0);
    add(1, 0, 1, 1, 0, 0, 16'h0000, 16'h1000, 1, 0);
    add(1, 0, 1, 1, 0, 1, 16'h9999, 16'h9999, 0, 0);
    add(3, 0, 1, 1, 0, 0, 16'h0000, 16'h9999, 0, 0);
    add(1, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 1, 1);
    add(1, 0, 1, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);
    add(3, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(1, 0, 1, 0, 0, 0, 16'h0000, 16'h9999, 1, 1);
    add(1, 0, 1, 0, 0, 0, 16'h0000, 16'h9999, 0, 0);
    add(1, 0, 1, 1, 0, 1, 16'hFA5C, 16'h9959, 0, 0);
    add(1, 0, 0, 1, 0, 1, 16'hA3F1, 16'h9391, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].c, vecs[i].l, vecs[i].d);
      check($sformatf("vec%0d.q", i),    q,         vecs[i].exp_q);
      check($sformatf("vec%0d.tick", i), 16'(tick), 16'(vecs[i].exp_tick));
      check($sformatf("vec%0d.wrap", i), 16'(wrap), 16'(vecs[i].exp_wrap));
    end

    // clr and load together while the prescaler sits on its last phase.
    cyc(0, 1, 1, 0, 1, 16'h0050);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 16'h0000);
    cyc(0, 1, 1, 1, 1, 16'h1234);
    check("prio.q", q, 16'h0000);
    check("prio.tick", 16'(tick), 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 0, 16'h0000);
      check_model("prio_wait");
    end
    cyc(0, 1, 1, 0, 0, 16'h0000);
    check("prio_step.q", q, 16'h0001);
    check("prio_step.tick", 16'(tick), 16'h0001);

    // en low for 10 cycles with the prescaler mid-way: nothing moves, phase resumes.
    cyc(0, 1, 1, 0, 1, 16'h0007);
    cyc(0, 1, 1, 0, 0, 16'h0000);
    cyc(0, 1, 1, 0, 0, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 0, 0, 16'h0000);
      check("hold.q", q, 16'h0007);
      check("hold.tick", 16'(tick), 16'h0000);
    end
    cyc(0, 1, 1, 0, 0, 16'h0000);
    check("resume1.q", q, 16'h0007);
    cyc(0, 1, 1, 0, 0, 16'h0000);
    check("resume2.q", q, 16'h0008);
    check("resume2.tick", 16'(tick), 16'h0001);

    // Reset for one cycle at q=0473 with p=2; next step needs a full DIV cycles.
    cyc(0, 1, 1, 0, 1, 16'h0473);
    cyc(0, 1, 1, 0, 0, 16'h0000);
    cyc(0, 1, 1, 0, 0, 16'h0000);
    check("pre_rst.q", q, 16'h0473);
    cyc(1, 1, 1, 0, 0, 16'h0000);
    check("rst.q", q, 16'h0000);
    check("rst.tick", 16'(tick), 16'h0000);
    check("rst.wrap", 16'(wrap), 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 0, 16'h0000);
      check("rst_wait.tick", 16'(tick), 16'h0000);
    end
    cyc(0, 1, 1, 0, 0, 16'h0000);
    check("rst_step.q", q, 16'h0001);
    check("rst_step.tick", 16'(tick), 16'h0001);

    // Randomized traffic against the model, biased toward long enabled runs.
    for (int i = 0; i < 600; i++) begin
      bit r, e, u, c, l;
      logic [15:0] d;
      r = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 3);
      l = ($urandom_range(0, 99) < 6);
      e = ($urandom_range(0, 99) < 80);
      u = (i % 200 < 100) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      d = 16'($urandom);
      if (l && $urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) != 0) ? 16'h9998 : 16'h0001;
      cyc(r, e, u, c, l, d);
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
